// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the DivMMC SD-card SPI master.
//   spi_state_t   : FSM states IDLE / LOW / HIGH (the SCK level being driven)
//   SPI_IDLE_DO   : level of mosi between transfers
//   SPI_DUMMY     : byte shifted out by a read (rx_strobe) transfer
//   DIV_W_DEFAULT : default width of the half-period counter
package sd_spi_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } spi_state_t;

  localparam logic       SPI_IDLE_DO   = 1'b1;
  localparam logic [7:0] SPI_DUMMY     = 8'hFF;
  localparam int         DIV_W_DEFAULT = 7;
endpackage

// File: rtl/sd_spi_master_if.sv
// Host-side bus of the SD SPI master (DivMMC port-0xEB decode side).
//   tx_strobe : level; rising edge starts a transfer of din
//   rx_strobe : level; rising edge starts a dummy 0xFF transfer
//   din       : byte to send
//   dout      : last fully received byte
//   busy      : transfer in progress
// Modports: master = host decode logic, slave = sd_spi_master.
interface sd_spi_master_if;
  logic       tx_strobe;
  logic       rx_strobe;
  logic [7:0] din;
  logic [7:0] dout;
  logic       busy;

  modport master (output tx_strobe, rx_strobe, din, input dout, busy);
  modport slave  (input tx_strobe, rx_strobe, din, output dout, busy);
endinterface

// File: rtl/sd_spi_baud.sv
// SCK half-period timer for the SD SPI master.
//   clk, reset_n : clock, asynchronous active-low reset
//   load         : (re)start the period; counter takes div
//   div          : reload value, i.e. half-period in clk cycles minus one
//   tick         : one-cycle pulse when the loaded period has elapsed
// The counter never wraps: after a tick it waits at zero until the next load.
module sd_spi_baud
  import sd_spi_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  logic [DIV_W-1:0] cnt_reg;
  logic             armed_reg;

  // armed_reg keeps the tick to a single cycle once the count has expired.
  assign tick = armed_reg && (cnt_reg == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg   <= '0;
      armed_reg <= 1'b0;
    end else if (load) begin
      cnt_reg   <= div;
      armed_reg <= 1'b1;
    end else if (tick) begin
      armed_reg <= 1'b0;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end
endmodule

// File: rtl/sd_spi_master.sv
// Byte-wide SPI master (mode 0, MSB first) for the DivMMC SD-card port.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : host bus (sd_spi_master_if.slave): tx/rx strobes, din, dout, busy
//   spi_clk      : SD sck
//   spi_do       : SD mosi
//   spi_di       : SD miso
//   slow         : selects DIV_SLOW half-period (only with SD_SPI_SLOW_INIT_EN)
// Optional feature macro: SD_SPI_SLOW_INIT_EN adds the slow port and DIV_SLOW.
// Chip-select is not handled here.
module sd_spi_master
  import sd_spi_pkg::*;
#(
  parameter int DIV_FAST = 2,
`ifdef SD_SPI_SLOW_INIT_EN
  parameter int DIV_SLOW = 64,
`endif
  parameter int DIV_W    = DIV_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  sd_spi_master_if.slave        bus,
  output logic                  spi_clk,
  output logic                  spi_do,
`ifdef SD_SPI_SLOW_INIT_EN
  input  logic                  slow,
`endif
  input  logic                  spi_di
);
  spi_state_t       state_reg;
  logic             busy_reg;
  logic             spi_clk_reg;
  logic             spi_do_reg;
  logic [7:0]       dout_reg;
  logic [7:0]       shreg_reg;
  logic [7:0]       rxreg_reg;
  logic [2:0]       bit_cnt_reg;
  logic             done_reg;

  logic [1:0]       strobe_in;
  logic [1:0]       strobe_q_reg;
  logic [1:0]       strobe_rise;
  logic             start;
  logic             accept;
  logic [7:0]       start_data;
  logic             tick;
  logic             baud_load;
  logic [DIV_W-1:0] baud_div;

  // Bit 0 = tx, bit 1 = rx. A strobe held high yields a single rising edge.
  assign strobe_in = {bus.rx_strobe, bus.tx_strobe};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) strobe_q_reg <= '0;
    else          strobe_q_reg <= strobe_in;
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_edge
    assign strobe_rise[gi] = strobe_in[gi] & ~strobe_q_reg[gi];
  end

  // Edges arriving while busy are consumed by the edge detector and dropped.
  assign start      = |strobe_rise;
  assign accept     = start && (state_reg == IDLE);
  assign start_data = strobe_rise[0] ? bus.din : SPI_DUMMY;

  // Reload at start and at every half-period end except the last one.
  assign baud_load = accept || (tick && !(state_reg == HIGH && done_reg));

`ifdef SD_SPI_SLOW_INIT_EN
  logic [DIV_W-1:0] div_start;
  logic [DIV_W-1:0] div_reg;

  assign div_start = slow ? DIV_W'(DIV_SLOW - 1) : DIV_W'(DIV_FAST - 1);

  // slow is latched at the start edge so the whole byte uses one rate.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    div_reg <= DIV_W'(DIV_FAST - 1);
    else if (accept) div_reg <= div_start;
  end

  assign baud_div = accept ? div_start : div_reg;
`else
  assign baud_div = DIV_W'(DIV_FAST - 1);
`endif

  sd_spi_baud #(.DIV_W(DIV_W)) u_baud (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (baud_load),
    .div     (baud_div),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      busy_reg    <= 1'b0;
      spi_clk_reg <= 1'b0;
      spi_do_reg  <= SPI_IDLE_DO;
      dout_reg    <= 8'hFF;
      shreg_reg   <= '0;
      rxreg_reg   <= '0;
      bit_cnt_reg <= '0;
      done_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            state_reg   <= LOW;
            busy_reg    <= 1'b1;
            shreg_reg   <= start_data;
            spi_do_reg  <= start_data[7];
            spi_clk_reg <= 1'b0;
            bit_cnt_reg <= '0;
            done_reg    <= 1'b0;
          end
        end
        LOW: begin
          if (tick) begin
            spi_clk_reg <= 1'b1;
            rxreg_reg   <= {rxreg_reg[6:0], spi_di};
            done_reg    <= (bit_cnt_reg == 3'd7);
            state_reg   <= HIGH;
          end
        end
        HIGH: begin
          if (tick) begin
            spi_clk_reg <= 1'b0;
            if (!done_reg) begin
              shreg_reg   <= {shreg_reg[6:0], 1'b0};
              spi_do_reg  <= shreg_reg[6];
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              state_reg   <= LOW;
            end else begin
              dout_reg   <= rxreg_reg;
              busy_reg   <= 1'b0;
              spi_do_reg <= SPI_IDLE_DO;
              state_reg  <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.dout = dout_reg;
  assign bus.busy = busy_reg;
  assign spi_clk  = spi_clk_reg;
  assign spi_do   = spi_do_reg;
endmodule
